// File: rtl/carry_normalizer.sv
`timescale 1ns/1ps
// Resolves a redundant signed-carry limb polynomial into one integer and reduces it into [0, MOD).
// Latency: accept edge to out_valid = ADD_DIV + 1 + n cycles (n = correction steps taken).
// Backpressure: one transaction in flight; in_ready only in IDLE, result held while out_ready is low.
module carry_normalizer #(
    parameter int ADD_DIV = 4,
    parameter int LIMB_W  = 64,
    parameter int CARRY_W = 8,
    parameter logic [ADD_DIV*LIMB_W-1:0] MOD =
        256'h2523648240000001BA344D80000000086121000000000013A700000000000013,
    parameter int MAX_RED = 15
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ADD_DIV*(LIMB_W+CARRY_W)-1:0]   in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ADD_DIV*LIMB_W-1:0]             out_data,
    output logic                                  out_err,
    output logic                                  busy
);

    localparam int SLOT_W = LIMB_W + CARRY_W;
    localparam int DATA_W = ADD_DIV * LIMB_W;
    localparam int C_W    = CARRY_W + 2;          // running carry / signed top word
    localparam int ACC_W  = DATA_W + C_W;
    localparam int T_W    = LIMB_W + 2;           // limb value plus signed carry-in
    localparam int K_W    = (ADD_DIV > 1) ? $clog2(ADD_DIV) : 1;
    localparam int N_W    = $clog2(MAX_RED + 1);
    localparam logic [ACC_W-1:0] MOD_EXT = {{C_W{1'b0}}, MOD};

    typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_REDUCE, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADD_DIV*SLOT_W-1:0] r_in;
    logic [C_W-1:0]     r_c;
    logic [K_W-1:0]     r_k;
    logic [N_W-1:0]     r_n;
    logic [ACC_W-1:0]   r_v;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_err;

    logic [SLOT_W-1:0]  w_slot;
    logic [LIMB_W-1:0]  w_val;
    logic [CARRY_W-1:0] w_carry;
    logic [T_W-1:0]     w_t;
    logic [C_W-1:0]     w_cnext;
    logic               w_neg;
    logic               w_big;
    logic               w_canon;
    logic               w_last_k;
    logic               w_nmax;

    // Current limb: t = val_k + c, carry out = (t >>> LIMB_W) + sext(carry_k)
    assign w_slot   = r_in[r_k*SLOT_W +: SLOT_W];
    assign w_val    = w_slot[LIMB_W-1:0];
    assign w_carry  = w_slot[SLOT_W-1:LIMB_W];
    assign w_t      = {2'b00, w_val} + {{(T_W-C_W){r_c[C_W-1]}}, r_c};
    assign w_cnext  = {{(C_W-2){w_t[T_W-1]}}, w_t[T_W-1:LIMB_W]}
                    + {{(C_W-CARRY_W){w_carry[CARRY_W-1]}}, w_carry};

    // Range classification of the signed accumulator V = {c, res}
    assign w_neg    = r_v[ACC_W-1];
    assign w_big    = !w_neg && (r_v >= MOD_EXT);
    assign w_canon  = !w_neg && !w_big;
    assign w_last_k = (r_k == K_W'(ADD_DIV-1));
    assign w_nmax   = (r_n == N_W'(MAX_RED));

    // State register; async reset drops any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decision
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (in_valid)              w_next = S_RESOLVE;
            S_RESOLVE: if (w_last_k)              w_next = S_REDUCE;
            S_REDUCE:  if (w_canon || w_nmax)     w_next = S_DONE;
            S_DONE:    if (out_ready)             w_next = S_IDLE;
            default:                              w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch input, resolve one limb per cycle, then one add/sub of MOD per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in       <= '0;
            r_c        <= '0;
            r_k        <= '0;
            r_n        <= '0;
            r_v        <= '0;
            r_out_data <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in <= in_data;
                        r_c  <= '0;
                        r_k  <= '0;
                        r_n  <= '0;
                        r_v  <= '0;
                    end
                end
                S_RESOLVE: begin
                    r_v[r_k*LIMB_W +: LIMB_W] <= w_t[LIMB_W-1:0];
                    r_c <= w_cnext;
                    r_k <= r_k + 1'b1;
                    // Final carry becomes the signed top word of V
                    if (w_last_k) r_v[ACC_W-1:DATA_W] <= w_cnext;
                end
                S_REDUCE: begin
                    if (w_canon) begin
                        r_out_data <= r_v[DATA_W-1:0];
                    end else if (w_nmax) begin
                        r_err      <= 1'b1;
                        r_out_data <= r_v[DATA_W-1:0];
                    end else begin
                        r_v <= w_neg ? (r_v + MOD_EXT) : (r_v - MOD_EXT);
                        r_n <= r_n + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_err  = r_err;

endmodule

// File: tb/tb_carry_normalizer.sv
`timescale 1ns/1ps
// Directed bench for carry_normalizer: driver pushes expected results, monitor pops on handshake.
module tb_carry_normalizer;

    localparam logic [255:0] P =
        256'h2523648240000001BA344D80000000086121000000000013A700000000000013;

    typedef struct {
        logic [255:0] data;
        logic         err;
        bit           chk_lat;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [287:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         out_err;
    logic         busy;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t_accept = 0;
    bit   seen     = 0;

    carry_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: latency on first out_valid, data/err on handshake
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else begin
            if (out_valid && !seen) begin
                seen = 1;
                if (sb.size() > 0 && sb[0].chk_lat)
                    check("latency", 256'(cyc - t_accept), 256'(sb[0].lat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 256'(1), 256'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_err", 256'(out_err), 256'(e.err));
                    if (!e.err) check("out_data", out_data, e.data);
                end
                seen = 0;
            end
        end
    end

    task automatic send(input logic [255:0] vals, input logic [31:0] cars,
                        input logic [255:0] ed, input logic ee, input bit cl, input int el);
        int   w;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            in_data[i*72 +: 64]    = vals[i*64 +: 64];
            in_data[i*72+64 +: 8]  = cars[i*8 +: 8];
        end
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_wait", 256'(in_ready), 256'(1));
        e.data = ed; e.err = ee; e.chk_lat = cl; e.lat = el;
        sb.push_back(e);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_accept = cyc;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain", 256'(sb.size()), 256'(0));
    endtask

    logic [255:0] d0;
    int           w;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        #3;
        check("rst_in_ready",  256'(in_ready),  256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_err",   256'(out_err),   256'(0));
        check("rst_out_data",  out_data,        256'(0));
        check("rst_busy",      256'(busy),      256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero carries: X = 1
        send(256'd1, 32'h0, 256'd1, 1'b0, 1'b1, 5);
        drain();
        // Carry ripple: X = 2^65 - 1
        send({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 32'h0000_0001,
             256'h1_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 5);
        drain();
        // Negative: X = 5 - 2^64, one +MOD step
        send(256'd5, 32'h0000_00FF, P - (256'd1 << 64) + 256'd5, 1'b0, 1'b1, 6);
        drain();
        // Exactly MOD: one subtraction to zero
        send(P, 32'h0, 256'd0, 1'b0, 1'b1, 6);
        drain();
        // One below the modulus: already canonical
        send(P - 256'd1, 32'h0, P - 256'd1, 1'b0, 1'b1, 5);
        drain();
        // Zero: no correction
        send(256'd0, 32'h0, 256'd0, 1'b0, 1'b1, 5);
        drain();
        // Mid-limb negative carry: X = 3*2^64 - 2^129
        send({128'd0, 64'd3, 64'd0}, 32'h0000_FE00,
             P - (256'd1 << 129) + (256'd3 << 64), 1'b0, 1'b1, 6);
        drain();

        // Async reset in the middle of RESOLVE drops the transaction
        send(256'd7, 32'h0, 256'd7, 1'b0, 1'b0, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_in_ready",  256'(in_ready),  256'(1));
        check("midrst_busy",      256'(busy),      256'(0));
        sb = {};
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(256'd9, 32'h0, 256'd9, 1'b0, 1'b1, 5);
        drain();

        // Overflow with backpressure: carry3 = +127 exceeds MAX_RED corrections
        out_ready = 1'b0;
        send(256'd0, 32'h7F00_0000, 256'd0, 1'b1, 1'b0, 0);
        w = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("bp_valid_seen", 256'(out_valid), 256'(1));
        d0 = out_data;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 256'(out_valid), 256'(1));
            check("bp_out_data",  out_data,        d0);
            check("bp_out_err",   256'(out_err),   256'(1));
            check("bp_in_ready",  256'(in_ready),  256'(0));
        end
        out_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        check("post_err_clear", 256'(out_err),  256'(0));
        check("post_in_ready",  256'(in_ready), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
